xor_frame_parity: RTL
=====================

# xor_frame_parity

Serial parity checker that consumes a bit stream produced by the XOR gate (one bit per accepted beat), groups bits into fixed-length frames, and checks each frame against its trailing parity bit. It reports per-frame pass/fail over a valid/ready handshake and keeps a saturating error count. It sits directly downstream of the XOR stage, between it and any result-logging or monitor logic.

## Interface
- DATA_BITS, 8, payload bits per frame, legal range >= 1
- ODD, 0, 0 = even parity (payload plus parity bit has an even number of ones), 1 = odd parity
- CNT_W, 8, width of error counter

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  serial data bit from XOR stage, LSB of payload first, parity bit last
- in_ready  out  1  block can accept a bit this cycle
- out_valid  out  1  frame result available
- out_ready  in  1  consumer accepts result
- out_parity_ok  out  1  1 = frame parity correct
- out_calc_parity  out  1  parity bit computed over payload (even/odd per ODD)
- err_count  out  CNT_W  number of failed frames, saturates at all-ones

## Operation
- FSM states: S_DATA, S_PAR, S_REPORT.
- S_DATA: on in_valid && in_ready, acc <= acc ^ in_bit and bit_cnt++. When the accepted bit has bit_cnt == DATA_BITS-1, go to S_PAR.
- S_PAR: on an accepted beat, latch out_calc_parity = acc ^ ODD and out_parity_ok = ((acc ^ in_bit) == ODD), then go to S_REPORT. If the frame fails and err_count is not all-ones, err_count increments.
- S_REPORT: out_valid = 1, in_ready = 0. On out_valid && out_ready: clear acc and bit_cnt, return to S_DATA.
- in_ready = (state != S_REPORT). No internal buffering: at most one result is held.
- bit_cnt width is max(1, clog2(DATA_BITS)). It never wraps past DATA_BITS-1.
- err_count never wraps. Once at 2^CNT_W-1 it holds until rst.
- in_bit is ignored whenever in_valid is 0 or in_ready is 0.

## Timing
- Reset values: in_ready 1 (state S_DATA), out_valid 0, out_parity_ok 0, out_calc_parity 0, err_count 0, acc 0, bit_cnt 0.
- Latency: out_valid rises on the first clk edge after the parity bit is accepted, and is visible the next cycle. Total frame cost: DATA_BITS+1 accepted beats, plus 1 cycle minimum in S_REPORT.
- A result handshake in cycle N permits a data beat in cycle N+1, not in cycle N.
- out_parity_ok, out_calc_parity and err_count stay stable while out_valid=1 && out_ready=0.
- out_ready held high: one bubble cycle per frame, so throughput is DATA_BITS+1 bits per DATA_BITS+2 cycles.
- Gaps (in_valid=0) anywhere inside a frame are legal and do not change state.
- rst asserted mid-frame or during S_REPORT discards the partial frame or pending result and returns all state to reset values on the next edge. rst has priority over every handshake in the same cycle.
- The err_count increment and the S_REPORT entry happen on the same edge.

## Structure
- Shared package/header:
  - state encodings S_DATA=2'd0, S_PAR=2'd1, S_REPORT=2'd2
  - default localparams for DATA_BITS and CNT_W
  - a clog2 function
- One sub-module is natural: sat_counter (parameter W; ports clk, rst, inc, count). It implements err_count.
- FSM, accumulator and bit counter stay in the top module.

## Test plan
- DATA_BITS=8, ODD=0: send payload 0xA5 LSB-first (1,0,1,0,0,1,0,1), then parity 0 -> out_valid after 1 cycle, out_parity_ok=1, out_calc_parity=0, err_count=0.
- Send payload 0x01, then parity 0 -> out_parity_ok=0, out_calc_parity=1, err_count=1. Repeat with parity 1 -> ok=1, err_count stays 1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, no bit consumed, outputs stable. Raise out_ready -> next frame 0xFF with parity 0 -> ok=1.
- CNT_W=2: send 5 bad frames back-to-back -> err_count sequence 1,2,3,3,3.
- Reset mid-frame: after 4 payload bits, pulse rst for 1 cycle -> all outputs at reset values. The next full frame 0x3C with parity 0 -> ok=1, which proves the partial bits were discarded.
- ODD=1, DATA_BITS=1: send payload 1, then parity 0 -> ok=1, calc=0. Payload 0, parity 0 -> ok=0, err_count=1.

Source files
------------

// File: rtl/xor_frame_parity_pkg.sv
// Shared types and helpers for the serial frame parity checker.
package xor_frame_parity_pkg;

    typedef enum logic [1:0] {
        S_DATA   = 2'd0,
        S_PAR    = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_CNT_W     = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/xor_frame_parity_sat_counter.sv
// Saturating up-counter: sticks at all-ones until reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/xor_frame_parity.sv
// Frames the XOR-stage bit stream, checks trailing parity and
// reports one result at a time over a valid/ready handshake.
module xor_frame_parity
    import xor_frame_parity_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter bit ODD       = 1'b0,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity_ok,
    output logic             out_calc_parity,
    output logic [CNT_W-1:0] err_count
);

    localparam int CW =
        (clog2(DATA_BITS) < 1) ? 1 : clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

    state_t        state;
    state_t        state_nxt;
    logic          acc;
    logic [CW-1:0] bit_cnt;
    logic          in_fire;
    logic          out_fire;
    logic          frame_bad;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign frame_bad = in_fire && (state == S_PAR) &&
                       ((acc ^ in_bit) != ODD);

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_DATA;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_DATA:
                if (in_fire && (bit_cnt == LAST))
                    state_nxt = S_PAR;
            S_PAR:
                if (in_fire)
                    state_nxt = S_REPORT;
            S_REPORT:
                if (out_fire)
                    state_nxt = S_DATA;
            default:
                state_nxt = S_DATA;
        endcase
    end

    always_comb begin
        in_ready  = (state != S_REPORT);
        out_valid = (state == S_REPORT);
    end

    // bit_cnt parks on the last index until the result is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            acc             <= 1'b0;
            bit_cnt         <= '0;
            out_parity_ok   <= 1'b0;
            out_calc_parity <= 1'b0;
        end else begin
            unique case (state)
                S_DATA:
                    if (in_fire) begin
                        acc <= acc ^ in_bit;
                        if (bit_cnt != LAST)
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                S_PAR:
                    if (in_fire) begin
                        out_calc_parity <= acc ^ ODD;
                        out_parity_ok   <= ((acc ^ in_bit) == ODD);
                    end
                S_REPORT:
                    if (out_fire) begin
                        acc     <= 1'b0;
                        bit_cnt <= '0;
                    end
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (frame_bad),
        .count (err_count)
    );

endmodule
